// File: rtl/fx_mst_if.sv
// fx_mst_if: command handshake plus fx register bus bundle.
// master = initiator view, slave = command source / bus side.
interface fx_mst_if #(
   parameter int AW = 16
);
   logic          cmd_req;
   logic          cmd_wr;
   logic [AW-1:0] cmd_addr;
   logic [7:0]    cmd_wdata;
   logic          cmd_busy;
   logic          cmd_ack;
   logic [7:0]    cmd_rdata;
   logic [AW-1:0] fx_addr;
   logic [7:0]    fx_data;
   logic          fx_wr;
   logic          fx_rd;
   logic [7:0]    fx_q;

   modport master (
      input  cmd_req, cmd_wr, cmd_addr, cmd_wdata, fx_q,
      output cmd_busy, cmd_ack, cmd_rdata,
      output fx_addr, fx_data, fx_wr, fx_rd
   );

   modport slave (
      output cmd_req, cmd_wr, cmd_addr, cmd_wdata, fx_q,
      input  cmd_busy, cmd_ack, cmd_rdata,
      input  fx_addr, fx_data, fx_wr, fx_rd
   );
endinterface

// File: rtl/fx_mst.sv
// fx_mst: single-command initiator for the fx register bus.
// All outputs registered; read data sampled after RD_LAT cycles.
module fx_mst #(
   parameter int AW      = 16,
   parameter int RD_LAT  = 2,
   parameter int WR_HOLD = 1
) (
   input logic      clk_sys,
   input logic      rst_n,
   fx_mst_if.master bus
);
   localparam int RL = (RD_LAT < 1) ? 1 : RD_LAT;
   localparam int WH = (WR_HOLD < 1) ? 1 : WR_HOLD;
   localparam logic [3:0] RL_M1 = 4'(RL - 1);
   localparam logic [3:0] WH_M1 = 4'(WH - 1);

   typedef enum logic [2:0] {
      IDLE, WR, RD, WAIT, DONE
   } state_t;

   state_t        state, state_d;
   logic [3:0]    cnt, cnt_d;
   logic [AW-1:0] addr, addr_d;
   logic [7:0]    data, data_d;
   logic [7:0]    rdata, rdata_d;
   logic          busy, busy_d;
   logic          ack, ack_d;
   logic          wr, wr_d;
   logic          rd, rd_d;

   // state and all registered outputs; reset clears strobes at once
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         addr  <= '0;
         data  <= '0;
         rdata <= '0;
         busy  <= 1'b0;
         ack   <= 1'b0;
         wr    <= 1'b0;
         rd    <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         addr  <= addr_d;
         data  <= data_d;
         rdata <= rdata_d;
         busy  <= busy_d;
         ack   <= ack_d;
         wr    <= wr_d;
         rd    <= rd_d;
      end
   end

   // next-state and next-output values for the registered outputs
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      addr_d  = addr;
      data_d  = data;
      rdata_d = rdata;
      busy_d  = busy;
      ack_d   = 1'b0;
      wr_d    = wr;
      rd_d    = rd;
      case (state)
         IDLE: begin
            if (bus.cmd_req) begin
               addr_d = bus.cmd_addr;
               data_d = bus.cmd_wdata;
               busy_d = 1'b1;
               if (bus.cmd_wr) begin
                  wr_d    = 1'b1;
                  cnt_d   = WH_M1;
                  state_d = WR;
               end else begin
                  rd_d    = 1'b1;
                  state_d = RD;
               end
            end
         end
         WR: begin
            if (cnt == 4'd0) begin
               wr_d    = 1'b0;
               ack_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end
         RD: begin
            rd_d    = 1'b0;
            cnt_d   = RL_M1;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               rdata_d = bus.fx_q;
               ack_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign bus.cmd_busy  = busy;
   assign bus.cmd_ack   = ack;
   assign bus.cmd_rdata = rdata;
   assign bus.fx_addr   = addr;
   assign bus.fx_data   = data;
   assign bus.fx_wr     = wr;
   assign bus.fx_rd     = rd;
endmodule

// File: tb/tb_fx_mst.sv
// tb_fx_mst: two fx_mst instances (RD_LAT/WR_HOLD 2/1 and 4/3)
// driven in parallel, checked against a timeline model and vectors.
module tb_fx_mst;
   localparam int AW = 16;

   logic clk_sys = 1'b0;
   logic rst_n   = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic          req;
   logic          wr;
   logic [AW-1:0] addr;
   logic [7:0]    wdata;
   logic [7:0]    q;

   fx_mst_if #(.AW(AW)) ia ();
   fx_mst_if #(.AW(AW)) ib ();

   assign ia.cmd_req   = req;
   assign ia.cmd_wr    = wr;
   assign ia.cmd_addr  = addr;
   assign ia.cmd_wdata = wdata;
   assign ia.fx_q      = q;
   assign ib.cmd_req   = req;
   assign ib.cmd_wr    = wr;
   assign ib.cmd_addr  = addr;
   assign ib.cmd_wdata = wdata;
   assign ib.fx_q      = q;

   fx_mst #(.AW(AW), .RD_LAT(2), .WR_HOLD(1)) dut_a (
      .clk_sys(clk_sys), .rst_n(rst_n), .bus(ia)
   );
   fx_mst #(.AW(AW), .RD_LAT(4), .WR_HOLD(3)) dut_b (
      .clk_sys(clk_sys), .rst_n(rst_n), .bus(ib)
   );

   typedef struct {
      bit          v;
      int          r;
      bit          wr;
      logic [15:0] addr;
      logic [7:0]  data;
   } txn_t;

   typedef struct {
      logic        busy;
      logic        wr;
      logic        rd;
      logic        ack;
      logic [7:0]  rdata;
      logic [15:0] addr;
      logic [7:0]  data;
   } obs_t;

   typedef struct {
      bit          req;
      bit          wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  q;
      bit          e_busy;
      bit          e_wr;
      bit          e_rd;
      bit          e_ack;
      logic [7:0]  e_rdata;
      logic [15:0] e_addr;
      logic [7:0]  e_data;
   } vec_t;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   int rl[2] = '{2, 4};
   int wh[2] = '{1, 3};

   txn_t        tx[2];
   logic [15:0] m_addr[2];
   logic [7:0]  m_data[2];
   logic [7:0]  m_rdata[2];
   int          ack_last[2];
   int          wr_cnt[2];
   int          wr_first[2];
   logic [7:0]  q_hist[0:4095];
   vec_t        vq[$];

   task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d cyc %0d: got %0h want %0h",
                    nm, d, cyc, act, exp);
   endtask

   function automatic obs_t get_obs(int d);
      obs_t o;
      if (d == 0) begin
         o = '{ia.cmd_busy, ia.fx_wr, ia.fx_rd, ia.cmd_ack,
               ia.cmd_rdata, ia.fx_addr, ia.fx_data};
      end else begin
         o = '{ib.cmd_busy, ib.fx_wr, ib.fx_rd, ib.cmd_ack,
               ib.cmd_rdata, ib.fx_addr, ib.fx_data};
      end
      return o;
   endfunction

   task automatic mdl_reset();
      for (int d = 0; d < 2; d++) begin
         tx[d].v    = 1'b0;
         m_addr[d]  = '0;
         m_data[d]  = '0;
         m_rdata[d] = '0;
      end
   endtask

   // timeline model: a request accepted in cycle r owns a fixed
   // window of bus activity and an ack cycle derived from r
   task automatic mdl_cycle(int d);
      obs_t o;
      int   ac;
      bit   eb, ew, er, ea;
      o  = get_obs(d);
      ac = tx[d].wr ? tx[d].r + wh[d] + 1 : tx[d].r + rl[d] + 2;
      if (tx[d].v && cyc == tx[d].r + 1) begin
         m_addr[d] = tx[d].addr;
         m_data[d] = tx[d].data;
      end
      if (tx[d].v && !tx[d].wr && cyc == ac)
         m_rdata[d] = q_hist[tx[d].r + rl[d] + 1];
      eb = tx[d].v && cyc > tx[d].r && cyc <= ac;
      ew = tx[d].v && tx[d].wr && cyc > tx[d].r &&
           cyc <= tx[d].r + wh[d];
      er = tx[d].v && !tx[d].wr && cyc == tx[d].r + 1;
      ea = tx[d].v && cyc == ac;
      chk("busy", d, 32'(o.busy), 32'(eb));
      chk("fx_wr", d, 32'(o.wr), 32'(ew));
      chk("fx_rd", d, 32'(o.rd), 32'(er));
      chk("ack", d, 32'(o.ack), 32'(ea));
      chk("rdata", d, 32'(o.rdata), 32'(m_rdata[d]));
      chk("fx_addr", d, 32'(o.addr), 32'(m_addr[d]));
      chk("fx_data", d, 32'(o.data), 32'(m_data[d]));
      if (o.ack) ack_last[d] = cyc;
      if (o.wr) begin
         wr_cnt[d]++;
         if (wr_first[d] < 0) wr_first[d] = cyc;
      end
      if (rst_n && req && !eb) tx[d] = '{1'b1, cyc, wr, addr, wdata};
   endtask

   task automatic drive(bit r, bit w, logic [15:0] a,
                        logic [7:0] dd, logic [7:0] qq);
      req   = r;
      wr    = w;
      addr  = a;
      wdata = dd;
      q     = qq;
      q_hist[cyc] = qq;
   endtask

   task automatic next_edge();
      @(posedge clk_sys);
      #1;
      cyc++;
   endtask

   task automatic cycle(bit r, bit w, logic [15:0] a,
                        logic [7:0] dd, logic [7:0] qq);
      drive(r, w, a, dd, qq);
      @(negedge clk_sys);
      mdl_cycle(0);
      mdl_cycle(1);
      next_edge();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 16'h0, 8'h0, 8'h0);
   endtask

   task automatic add(bit r, bit w, logic [15:0] a, logic [7:0] dd,
                      logic [7:0] qq, bit eb, bit ew, bit er, bit ea,
                      logic [7:0] erd, logic [15:0] ead,
                      logic [7:0] edt);
      vec_t v;
      v = '{r, w, a, dd, qq, eb, ew, er, ea, erd, ead, edt};
      vq.push_back(v);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t o;
      int   r0;
      drive(0, 0, 16'h0, 8'h0, 8'h0);
      mdl_reset();
      for (int d = 0; d < 2; d++) begin
         ack_last[d] = -1;
         wr_cnt[d]   = 0;
         wr_first[d] = -1;
      end
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys);
      for (int d = 0; d < 2; d++) begin
         o = get_obs(d);
         chk("rst_busy", d, 32'(o.busy), 32'h0);
         chk("rst_ack", d, 32'(o.ack), 32'h0);
         chk("rst_wr", d, 32'(o.wr), 32'h0);
         chk("rst_rd", d, 32'(o.rd), 32'h0);
         chk("rst_rdata", d, 32'(o.rdata), 32'h0);
         chk("rst_addr", d, 32'(o.addr), 32'h0);
         chk("rst_data", d, 32'(o.data), 32'h0);
      end
      #2 rst_n = 1'b1;
      next_edge();
      cyc = 0;

      // write 0x0123 <- 0xA5
      add(1, 1, 16'h0123, 8'hA5, 8'h00, 0, 0, 0, 0, 8'h00, 16'h0000, 8'h00);
      add(0, 0, 16'h0000, 8'h00, 8'hFF, 1, 1, 0, 0, 8'h00, 16'h0123, 8'hA5);
      add(0, 0, 16'h0000, 8'h00, 8'hFF, 1, 0, 0, 1, 8'h00, 16'h0000, 8'h00);
      add(0, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 16'h0000, 8'h00);
      // read with 0x5C only in the sample cycle
      add(1, 0, 16'h0456, 8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 16'h0000, 8'h00);
      add(0, 0, 16'h0000, 8'h00, 8'hFF, 1, 0, 1, 0, 8'h00, 16'h0456, 8'h00);
      add(0, 0, 16'h0000, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 16'h0000, 8'h00);
      add(0, 0, 16'h0000, 8'h00, 8'h5C, 1, 0, 0, 0, 8'h00, 16'h0000, 8'h00);
      add(0, 0, 16'h0000, 8'h00, 8'hFF, 1, 0, 0, 1, 8'h5C, 16'h0000, 8'h00);
      add(0, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 8'h5C, 16'h0000, 8'h00);
      // unmapped read, then a write leaves rdata alone
      add(1, 0, 16'h0777, 8'h00, 8'h00, 0, 0, 0, 0, 8'h5C, 16'h0000, 8'h00);
      add(0, 0, 16'h0000, 8'h00, 8'h00, 1, 0, 1, 0, 8'h5C, 16'h0777, 8'h00);
      add(0, 0, 16'h0000, 8'h00, 8'h00, 1, 0, 0, 0, 8'h5C, 16'h0000, 8'h00);
      add(0, 0, 16'h0000, 8'h00, 8'h00, 1, 0, 0, 0, 8'h5C, 16'h0000, 8'h00);
      add(0, 0, 16'h0000, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 16'h0000, 8'h00);
      add(1, 1, 16'h0010, 8'h3C, 8'h00, 0, 0, 0, 0, 8'h00, 16'h0000, 8'h00);
      add(0, 0, 16'h0000, 8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 16'h0010, 8'h3C);
      add(0, 0, 16'h0000, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 16'h0000, 8'h00);
      add(0, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 16'h0000, 8'h00);
      // requests while busy (and on ack) are dropped
      add(1, 0, 16'h0100, 8'h00, 8'h11, 0, 0, 0, 0, 8'h00, 16'h0000, 8'h00);
      add(1, 1, 16'h0200, 8'h99, 8'h22, 1, 0, 1, 0, 8'h00, 16'h0100, 8'h00);
      add(1, 1, 16'h0200, 8'h99, 8'h33, 1, 0, 0, 0, 8'h00, 16'h0000, 8'h00);
      add(1, 1, 16'h0200, 8'h99, 8'h44, 1, 0, 0, 0, 8'h00, 16'h0000, 8'h00);
      add(1, 1, 16'h0200, 8'h99, 8'h55, 1, 0, 0, 1, 8'h44, 16'h0000, 8'h00);
      add(1, 1, 16'h0300, 8'h77, 8'h00, 0, 0, 0, 0, 8'h44, 16'h0000, 8'h00);
      add(0, 0, 16'h0000, 8'h00, 8'h00, 1, 1, 0, 0, 8'h44, 16'h0300, 8'h77);
      add(0, 0, 16'h0000, 8'h00, 8'h00, 1, 0, 0, 1, 8'h44, 16'h0000, 8'h00);
      add(0, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 8'h44, 16'h0000, 8'h00);

      foreach (vq[i]) begin
         drive(vq[i].req, vq[i].wr, vq[i].addr, vq[i].wdata, vq[i].q);
         @(negedge clk_sys);
         o = get_obs(0);
         chk("tbl_busy", i, 32'(o.busy), 32'(vq[i].e_busy));
         chk("tbl_wr", i, 32'(o.wr), 32'(vq[i].e_wr));
         chk("tbl_rd", i, 32'(o.rd), 32'(vq[i].e_rd));
         chk("tbl_ack", i, 32'(o.ack), 32'(vq[i].e_ack));
         chk("tbl_rdata", i, 32'(o.rdata), 32'(vq[i].e_rdata));
         if (vq[i].e_wr || vq[i].e_rd) begin
            chk("tbl_addr", i, 32'(o.addr), 32'(vq[i].e_addr));
            chk("tbl_data", i, 32'(o.data), 32'(vq[i].e_data));
         end
         mdl_cycle(0);
         mdl_cycle(1);
         next_edge();
      end

      // reset in the middle of a read
      idle(8);
      cycle(1, 0, 16'h0ABC, 8'h00, 8'h00);
      cycle(0, 0, 16'h0000, 8'h00, 8'h00);
      drive(0, 0, 16'h0, 8'h0, 8'h0);
      #2 rst_n = 1'b0;
      mdl_reset();
      #1;
      for (int d = 0; d < 2; d++) begin
         o = get_obs(d);
         chk("rst_mid_rd", d, 32'(o.rd), 32'h0);
         chk("rst_mid_busy", d, 32'(o.busy), 32'h0);
         chk("rst_mid_ack", d, 32'(o.ack), 32'h0);
      end
      @(negedge clk_sys);
      mdl_cycle(0);
      mdl_cycle(1);
      next_edge();
      drive(0, 0, 16'h0, 8'h0, 8'h0);
      #2 rst_n = 1'b1;
      @(negedge clk_sys);
      mdl_cycle(0);
      mdl_cycle(1);
      next_edge();
      ack_last[0] = -1;
      ack_last[1] = -1;
      idle(8);
      chk("no_ack_after_rst", 0, 32'(ack_last[0]), 32'hFFFF_FFFF);
      chk("no_ack_after_rst", 1, 32'(ack_last[1]), 32'hFFFF_FFFF);
      r0 = cyc;
      cycle(1, 0, 16'h0ABD, 8'h00, 8'h00);
      cycle(0, 0, 16'h0000, 8'h00, 8'h00);
      cycle(0, 0, 16'h0000, 8'h00, 8'h00);
      cycle(0, 0, 16'h0000, 8'h00, 8'h6E);
      cycle(0, 0, 16'h0000, 8'h00, 8'h00);
      chk("post_rst_ack_lat", 0, 32'(ack_last[0] - r0), 32'd4);
      chk("post_rst_rdata", 0, 32'(ia.cmd_rdata), 32'h6E);

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         cycle($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
               16'($urandom), 8'($urandom), 8'($urandom));
      end

      // latency sweep on the RD_LAT=4 / WR_HOLD=3 instance
      idle(10);
      ack_last[1] = -1;
      r0 = cyc;
      cycle(1, 0, 16'h0042, 8'h00, 8'h00);
      idle(10);
      chk("sweep_rd_ack", 1, 32'(ack_last[1] - r0), 32'd6);
      ack_last[1] = -1;
      wr_cnt[1]   = 0;
      wr_first[1] = -1;
      r0 = cyc;
      cycle(1, 1, 16'h0043, 8'hC3, 8'h00);
      idle(10);
      chk("sweep_wr_len", 1, 32'(wr_cnt[1]), 32'd3);
      chk("sweep_wr_first", 1, 32'(wr_first[1] - r0), 32'd1);
      chk("sweep_wr_ack", 1, 32'(ack_last[1] - r0), 32'd4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fx_mst.md
Name: fx_mst

Overview:
- Initiator for the FPGA-internal fx register bus.
- Takes single read/write commands over a simple req/ack handshake and drives fx_addr/fx_data/fx_wr/fx_rd.
- For reads, captures the OR-combined slave read bus fx_q after a fixed read latency.
- Sits between the host-interface command decoder and all fx slaves (syn, ad1..ad3, dsp).

Parameters:
- AW, 16, fx address width.
- RD_LAT, 2, cycles from fx_rd assertion to fx_q valid. Legal 1..15; values <1 are clamped to 1.
- WR_HOLD, 1, number of cycles fx_wr is held high per write. Legal 1..15; values <1 are clamped to 1.

Ports:
- clk_sys  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_req  in  1  command strobe; sampled only while cmd_busy=0
- cmd_wr  in  1  1 = write, 0 = read; qualified by cmd_req
- cmd_addr  in  AW  target fx address
- cmd_wdata  in  8  write data
- cmd_busy  out  1  command in progress, new requests ignored
- cmd_ack  out  1  one-cycle completion pulse
- cmd_rdata  out  8  read result; valid while cmd_ack=1, then held
- fx_addr  out  AW  bus address
- fx_data  out  8  bus write data
- fx_wr  out  1  bus write strobe
- fx_rd  out  1  bus read strobe
- fx_q  in  8  OR-combined slave read data (0x00 when no slave drives)

Behaviour:
- Clock and reset: one clock, clk_sys. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; counter 0. Outputs are registered, no combinational input-to-output paths.
- States: IDLE, WR, RD, WAIT, DONE.
- IDLE:
  - cmd_busy=0.
  - cmd_req=1 at edge ending cycle R latches cmd_addr, cmd_wdata and cmd_wr.
  - fx_addr/fx_data take the latched values in cycle R+1; cmd_busy=1 from R+1.
  - Next state is WR if cmd_wr=1, else RD.
- WR:
  - fx_wr=1 for cycles R+1..R+WR_HOLD, using a 4-bit down-counter.
  - fx_addr/fx_data are stable throughout.
  - Then DONE.
- RD:
  - fx_rd=1 for exactly one cycle (R+1); fx_addr stable.
  - Then WAIT.
- WAIT:
  - Counts RD_LAT cycles (R+2..R+RD_LAT+1).
  - fx_q is sampled into cmd_rdata only at the edge ending cycle R+1+RD_LAT; fx_q in every other cycle is ignored.
  - Then DONE.
- DONE:
  - cmd_ack=1 for one cycle, cmd_busy still 1, fx_wr=fx_rd=0.
  - Then IDLE.
- Latency from request edge to ack cycle:
  - Write: ack in cycle R+WR_HOLD+1.
  - Read: ack in cycle R+RD_LAT+2.
  - Next request can be accepted in the cycle after ack.
- fx_addr/fx_data hold their last values in IDLE; they never change while fx_wr or fx_rd is high.
- cmd_rdata holds its last read value until the next read capture. Writes do not modify it.
- cmd_req while cmd_busy=1 (including the ack cycle) is dropped: no queueing, no error flag. The requester must issue requests only when cmd_busy=0.
- fx_wr and fx_rd are never high in the same cycle.
- Reset asserted mid-command: immediate return to reset values. No ack is issued for the aborted command; the bus strobe drops asynchronously.

Test Plan:
- Write, WR_HOLD=1: cmd_req, cmd_wr=1, addr 0x0123, data 0xA5 at cycle 0 -> fx_wr high only in cycle 1 with fx_addr=0x0123 and fx_data=0xA5; cmd_ack in cycle 2; cmd_busy high in cycles 1-2.
- Read, RD_LAT=2: slave model drives fx_q=0x5C in cycle 3 only and 0xFF in cycles 1, 2 and 4 -> fx_rd high only in cycle 1; cmd_ack in cycle 4 with cmd_rdata=0x5C.
- Unmapped read: fx_q held 0x00 -> cmd_rdata=0x00 with ack. A subsequent write leaves cmd_rdata at 0x00.
- Busy rejection: second cmd_req (write, addr 0x0200) during cycles 1-3 of a read -> ignored, exactly one ack and one fx_rd pulse. A request in the cycle after ack is accepted.
- Reset mid-read: rst_n low in cycle 2 of a read -> fx_rd, cmd_busy and cmd_ack are 0 immediately. No ack appears after reset release; the next read completes normally.
- Parameter sweep RD_LAT=4, WR_HOLD=3: read ack at cycle 6; write has fx_wr high in cycles 1-3 and ack at cycle 4.
